// File: rtl/pipeline_stage_buffer_if.sv
// Handshake bundle between two CPU pipeline stages: upstream valid/ready/payload,
// downstream valid/ready/payload, flush and occupancy status.
interface pipeline_stage_buffer_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  // Environment side: feeds the upstream entry and the downstream ready.
  modport master (
    output flush, in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, occupancy
  );

  // Buffer side.
  modport slave (
    input  flush, in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, occupancy
  );
endinterface

// File: rtl/pipeline_stage_buffer.sv
// Pipeline barrier with a 2-entry skid buffer: registered in_ready, strict FIFO order,
// flush, and zeroed control on bubbles so RegWrite/MemToReg never fire on empty slots.
module pipeline_stage_buffer #(
  parameter int DATA_W    = 32,
  parameter int CTRL_W    = 8,
  parameter bit ZERO_CTRL = 1'b1
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_stage_buffer_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  state_t            stateNext;
  logic [DATA_W-1:0] mainData;
  logic [DATA_W-1:0] skidData;
  logic [CTRL_W-1:0] mainCtrl;
  logic [CTRL_W-1:0] skidCtrl;
  logic              mainValid;
  logic              skidValid;
  logic              inFire;
  logic              outFire;
  logic              loadMainIn;
  logic              loadMainSkid;
  logic              loadSkid;

  // Valid bits are decoded from the state, so skid can never be valid without main.
  assign mainValid = (state != EMPTY);
  assign skidValid = (state == FULL);

  assign bus.in_ready  = ~skidValid;
  assign inFire        = bus.in_valid & ~skidValid;
  assign outFire       = mainValid & bus.out_ready;

  assign bus.out_valid = mainValid;
  assign bus.out_data  = mainData;
  assign bus.out_ctrl  = (ZERO_CTRL && !mainValid) ? '0 : mainCtrl;
  assign bus.occupancy = {1'b0, mainValid} + {1'b0, skidValid};

  always_comb begin
    stateNext    = state;
    loadMainIn   = 1'b0;
    loadMainSkid = 1'b0;
    loadSkid     = 1'b0;
    if (bus.flush) begin
      stateNext = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (inFire) begin
            loadMainIn = 1'b1;
            stateNext  = ONE;
          end
        end
        ONE: begin
          case ({inFire, outFire})
            2'b11: loadMainIn = 1'b1;
            2'b10: begin
              loadSkid  = 1'b1;
              stateNext = FULL;
            end
            2'b01: stateNext = EMPTY;
            default: stateNext = ONE;
          endcase
        end
        FULL: begin
          if (outFire) begin
            loadMainSkid = 1'b1;
            stateNext    = ONE;
          end
        end
        default: stateNext = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= stateNext;
    end
  end

  // Payload registers: cleared on reset so out_data/out_ctrl read 0 afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      mainData <= '0;
      mainCtrl <= '0;
      skidData <= '0;
      skidCtrl <= '0;
    end else begin
      if (loadMainIn) begin
        mainData <= bus.in_data;
        mainCtrl <= bus.in_ctrl;
      end else if (loadMainSkid) begin
        mainData <= skidData;
        mainCtrl <= skidCtrl;
      end
      if (loadSkid) begin
        skidData <= bus.in_data;
        skidCtrl <= bus.in_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stage_buffer.sv
// Directed bench for pipeline_stage_buffer with a queue-based scoreboard of accepted entries.
module tb_pipeline_stage_buffer;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [39:0] sbq[$];
  logic [39:0] expEntry;

  pipeline_stage_buffer_if #(.DATA_W(32), .CTRL_W(8)) bus ();

  pipeline_stage_buffer #(.DATA_W(32), .CTRL_W(8), .ZERO_CTRL(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog cycle budget expired, required summary before 5000 cycles");
    $fatal(1, "watchdog");
  end

  // Accepted inputs enter the queue; every downstream transfer is checked against its head.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got ctrl=%h data=%h, required no output", bus.out_ctrl, bus.out_data);
      end else begin
        expEntry = sbq.pop_front();
        if ({bus.out_ctrl, bus.out_data} !== expEntry) begin
          errors++;
          $display("FAIL sb_order got %h required %h", {bus.out_ctrl, bus.out_data}, expEntry);
        end
      end
    end
    if (reset || bus.flush) sbq.delete();
    else if (bus.in_valid && bus.in_ready) sbq.push_back({bus.in_ctrl, bus.in_data});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [7:0] c);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_ctrl  = c;
    step();
  endtask

  int  nextVal;
  bit  fired;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hFFFF_FFFF;
    bus.in_ctrl   = 8'hFF;
    bus.out_ready = 1'b0;

    // Reset with in_valid held high
    step();
    step();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_occupancy", bus.occupancy, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_ctrl", bus.out_ctrl, 0);
    check("rst_out_data", bus.out_data, 0);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    step();

    // Single transfer
    bus.out_ready = 1'b1;
    push(32'hDEADBEEF, 8'h03);
    bus.in_valid = 1'b0;
    check("single_out_valid", bus.out_valid, 1);
    check("single_out_data", bus.out_data, 64'hDEADBEEF);
    check("single_out_ctrl", bus.out_ctrl, 64'h03);
    step();
    check("single_occ_after", bus.occupancy, 0);
    check("single_ctrl_bubble", bus.out_ctrl, 0);
    check("single_data_hold", bus.out_data, 64'hDEADBEEF);

    // Back-pressure
    bus.out_ready = 1'b0;
    push(32'd1, 8'h11);
    push(32'd2, 8'h12);
    check("bp_occ_full", bus.occupancy, 2);
    check("bp_in_ready", bus.in_ready, 0);
    push(32'd3, 8'h13);
    check("bp_occ_hold", bus.occupancy, 2);
    check("bp_head", bus.out_data, 1);
    bus.out_ready = 1'b1;
    step();
    check("bp_second", bus.out_data, 2);
    step();
    bus.in_valid = 1'b0;
    check("bp_third", bus.out_data, 3);
    check("bp_third_occ", bus.occupancy, 1);
    step();
    check("bp_drained", bus.occupancy, 0);

    // Streaming at full throughput
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      push(32'(i), i[7:0]);
      check("stream_occ", bus.occupancy, 1);
      check("stream_latency", bus.out_data, 64'(i));
    end
    bus.in_valid = 1'b0;
    step();
    check("stream_empty", bus.occupancy, 0);

    // Random downstream stalls
    nextVal = 1000;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if (!bus.in_valid) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = 32'(nextVal);
        bus.in_ctrl  = nextVal[7:0];
      end
      fired = bus.in_valid && bus.in_ready;
      step();
      if (fired) begin
        nextVal++;
        bus.in_valid = 1'b0;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) step();
    check("rand_sb_empty", sbq.size(), 0);
    check("rand_some_traffic", (nextVal > 1050), 1);

    // Flush while FULL
    bus.out_ready = 1'b0;
    push(32'hA1, 8'hA1);
    push(32'hA2, 8'hA2);
    check("flush_pre_full", bus.occupancy, 2);
    bus.in_data  = 32'hA3;
    bus.in_ctrl  = 8'hA3;
    bus.flush    = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_occ", bus.occupancy, 0);
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_out_ctrl", bus.out_ctrl, 0);
    bus.out_ready = 1'b1;
    repeat (3) step();
    check("flush_stays_empty", bus.out_valid, 0);

    // Flush from ONE with in_ready=1 discards the presented input
    bus.out_ready = 1'b0;
    push(32'hB1, 8'hB1);
    bus.in_data  = 32'hB2;
    bus.in_ctrl  = 8'hB2;
    bus.flush    = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush1_occ", bus.occupancy, 0);
    bus.out_ready = 1'b1;
    repeat (2) step();
    check("flush1_empty", bus.out_valid, 0);

    // Reset mid-operation while FULL
    bus.out_ready = 1'b0;
    push(32'hC1, 8'hC1);
    push(32'hC2, 8'hC2);
    bus.in_data = 32'hC3;
    bus.in_ctrl = 8'hC3;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    check("mrst_occ", bus.occupancy, 0);
    check("mrst_out_valid", bus.out_valid, 0);
    check("mrst_in_ready", bus.in_ready, 1);
    check("mrst_out_data", bus.out_data, 0);
    check("mrst_out_ctrl", bus.out_ctrl, 0);
    bus.out_ready = 1'b1;
    push(32'h55, 8'h55);
    bus.in_valid = 1'b0;
    check("mrst_push_data", bus.out_data, 64'h55);
    check("mrst_push_ctrl", bus.out_ctrl, 64'h55);
    step();
    check("mrst_push_drained", bus.occupancy, 0);
    check("final_sb_empty", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
